// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default format, canonical constants and
// the accumulator state encoding.
package fp_pkg;

    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_WIDTH  = 1 + FP_EXP_W + FP_FRAC_W;

    localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = '0;
    localparam logic [FP_WIDTH-1:0] FP_QNAN     = {1'b0, {FP_EXP_W{1'b1}}, 1'b1,
                                                   {(FP_FRAC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } acc_state_e;

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 adder, round-to-nearest-even, subnormals supported.
// Any NaN input or +Inf + -Inf yields the canonical quiet NaN.
module fp_add
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned FRAC_W = FP_FRAC_W
) (
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    output logic [EXP_W+FRAC_W:0] y
);

    localparam int unsigned W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned M  = FRAC_W + 1;
    localparam int unsigned MW = M + 1;
    localparam int unsigned X  = M + 3;
    localparam int unsigned EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    logic             a_nan, b_nan, a_inf, b_inf, eff_sub, a_ge;
    logic [W-1:0]     big;
    logic [W-2:0]     sml;
    logic [EXP_W-1:0] e_big, e_sml, d;
    logic [X-1:0]     m_big, m_sml, m_shr, norm;
    logic [X:0]       sum;
    logic [EW-1:0]    e_res;
    logic [M:0]       mant;
    logic             rnd;
    int unsigned      lz, sh;

    assign a_nan   = (a[W-2:FRAC_W] == EXP_MAX) && (a[FRAC_W-1:0] != '0);
    assign b_nan   = (b[W-2:FRAC_W] == EXP_MAX) && (b[FRAC_W-1:0] != '0);
    assign a_inf   = (a[W-2:FRAC_W] == EXP_MAX) && (a[FRAC_W-1:0] == '0);
    assign b_inf   = (b[W-2:FRAC_W] == EXP_MAX) && (b[FRAC_W-1:0] == '0);
    assign eff_sub = a[W-1] ^ b[W-1];

    // Larger magnitude goes first so the subtraction never goes negative.
    assign a_ge  = a[W-2:0] >= b[W-2:0];
    assign big   = a_ge ? a : b;
    assign sml   = a_ge ? b[W-2:0] : a[W-2:0];
    assign e_big = (big[W-2:FRAC_W] == '0) ? EXP_W'(1) : big[W-2:FRAC_W];
    assign e_sml = (sml[W-2:FRAC_W] == '0) ? EXP_W'(1) : sml[W-2:FRAC_W];
    assign d     = e_big - e_sml;
    assign m_big = {big[W-2:FRAC_W] != '0, big[FRAC_W-1:0], 3'b000};
    assign m_sml = {sml[W-2:FRAC_W] != '0, sml[FRAC_W-1:0], 3'b000};

    always_comb begin
        if (32'(d) >= X) begin
            m_shr = {{(X-1){1'b0}}, |m_sml};
        end else begin
            m_shr = (m_sml >> d) | {{(X-1){1'b0}}, |(m_sml & ~({X{1'b1}} << d))};
        end
    end

    assign sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_shr}) : ({1'b0, m_big} + {1'b0, m_shr});

    always_comb begin
        lz = X;
        for (int i = 0; i < X; i++) begin
            if (sum[i]) lz = X - 1 - i;
        end
        e_res = {2'b00, e_big};
        if (sum[X]) begin
            norm  = {sum[X:2], sum[1] | sum[0]};
            e_res = e_res + EW'(1);
            sh    = 0;
        end else begin
            // Stop shifting at the minimum exponent to produce a subnormal.
            sh    = (lz < 32'(e_res) - 32'd1) ? lz : 32'(e_res) - 32'd1;
            norm  = sum[X-1:0] << sh;
            e_res = e_res - EW'(sh);
        end

        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[X-1:3]} + MW'(rnd);
        if (mant[M]) begin
            mant  = mant >> 1;
            e_res = e_res + EW'(1);
        end

        y = {big[W-1], (mant[M-1] ? e_res[EXP_W-1:0] : {EXP_W{1'b0}}), mant[FRAC_W-1:0]};
        if (mant[M-1] && (e_res >= {2'b00, EXP_MAX})) begin
            y = {big[W-1], EXP_MAX, {FRAC_W{1'b0}}};
        end
        if (sum == '0) begin
            y = {~eff_sub & big[W-1], {(W-1){1'b0}}};
        end
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            y = QNAN;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end
    end

endmodule

// File: rtl/fp_dot_acc.sv
// Streaming accumulator: sums in_last-delimited vectors of FP products and
// presents each sum with its saturating element count on a valid/ready output.
module fp_dot_acc
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned FRAC_W = FP_FRAC_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_data,
    output logic [CNT_W-1:0]      out_count
);

    localparam int unsigned WIDTH = 1 + EXP_W + FRAC_W;

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             accept;

    fp_add #(
        .EXP_W (EXP_W),
        .FRAC_W(FRAC_W)
    ) u_fp_add (
        .a(acc_q),
        .b(in_data),
        .y(sum)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !clr;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (clr) begin
            // Abort wins over the element offered this cycle; pending result untouched.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                ACCUM: begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sum;
                        out_count_d = cnt_inc;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    // First element is loaded verbatim so a lone -0.0 survives.
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        out_count_d = CNT_W'(1);
                    end else begin
                        acc_d   = in_data;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule
